alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Two-requester front end sharing one combinational ALU: arbitrate, latch, execute, hold result.
// Each requester gets its own result register so a response is never disturbed by the other side.

module alu #(
  parameter int DATA_W = 32
) (
  input  logic        [3:0]        ctl,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] out,
  output logic                     zero
);

  always_comb begin
    out = '0;
    case (ctl)
      4'd0:    out = a & b;
      4'd1:    out = a | b;
      4'd2:    out = a + b;
      4'd6:    out = a - b;
      4'd7:    out = (a < b) ? {{(DATA_W-1){1'b0}}, 1'b1} : '0;
      4'd12:   out = ~(a | b);
      4'd13:   out = a ^ b;
      default: out = '0;
    endcase
    zero = (out == '0);
  end

endmodule

module alu_arbiter #(
  parameter bit FIXED_PRIO = 1'b0,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [3:0]        req0_ctl,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [3:0]        req1_ctl,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_out,
  output logic              rsp0_zero,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_out,
  output logic              rsp1_zero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]               state;
  logic                     last_grant;
  logic                     win;
  logic                     accept;
  logic                     grant_p0;
  logic [3:0]               ctl_p0;
  logic signed [DATA_W-1:0] a_p0;
  logic signed [DATA_W-1:0] b_p0;
  logic signed [DATA_W-1:0] alu_out;
  logic                     alu_zero;
  logic signed [DATA_W-1:0] out0_p1;
  logic signed [DATA_W-1:0] out1_p1;
  logic                     zero0_p1;
  logic                     zero1_p1;

  // win is only meaningful when at least one requester is valid
  always_comb begin
    if (FIXED_PRIO) begin
      win = ~req0_valid;
    end else if (req0_valid && req1_valid) begin
      win = ~last_grant;
    end else begin
      win = req1_valid;
    end
    accept     = (state == IDLE) && (req0_valid || req1_valid) && !reset;
    req0_ready = accept && !win;
    req1_ready = accept && win;
    rsp0_valid = (state == RESP) && !grant_p0 && !reset;
    rsp1_valid = (state == RESP) && grant_p0 && !reset;
  end

  alu #(.DATA_W(DATA_W)) u_alu (
    .ctl  (ctl_p0),
    .a    (a_p0),
    .b    (b_p0),
    .out  (alu_out),
    .zero (alu_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant_p0   <= 1'b0;
      ctl_p0     <= '0;
      a_p0       <= '0;
      b_p0       <= '0;
      out0_p1    <= '0;
      out1_p1    <= '0;
      zero0_p1   <= 1'b0;
      zero1_p1   <= 1'b0;
    end else begin
      case (state)
        // p0: capture the winning operation
        IDLE: begin
          if (accept) begin
            grant_p0 <= win;
            ctl_p0   <= win ? req1_ctl : req0_ctl;
            a_p0     <= win ? req1_a : req0_a;
            b_p0     <= win ? req1_b : req0_b;
            if (!FIXED_PRIO) last_grant <= win;
            state    <= EXEC;
          end
        end
        // p1: register the ALU result into the granted requester's slot
        EXEC: begin
          if (grant_p0) begin
            out1_p1  <= alu_out;
            zero1_p1 <= alu_zero;
          end else begin
            out0_p1  <= alu_out;
            zero0_p1 <= alu_zero;
          end
          state <= RESP;
        end
        RESP: begin
          if (grant_p0 ? rsp1_ready : rsp0_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rsp0_out  = out0_p1;
  assign rsp0_zero = zero0_p1;
  assign rsp1_out  = out1_p1;
  assign rsp1_zero = zero1_p1;

endmodule
